// File: rtl/score_bcd_formatter_if.sv
// Handshake/data bundle between the score logic and the BCD formatter.
// The formatter's hexs/LEs outputs feed the display stage directly.
interface score_bcd_formatter_if #(
  parameter int BIN_W = 14
);
  logic [BIN_W-1:0] bin;
  logic             start;
  logic             busy;
  logic             done;
  logic [15:0]      hexs;
  logic [3:0]       LEs;

  modport master (output bin, start, input busy, done, hexs, LEs);
  modport slave  (input bin, start, output busy, done, hexs, LEs);
endinterface

// File: rtl/score_bcd_formatter.sv
// Saturating binary -> 4-digit packed BCD using an iterative double-dabble engine.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN enables leading-zero blanking in LEs.
module score_bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  // 4-bit wrap is harmless: the input never exceeds 9, so the result never exceeds 12.
  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

module score_bcd_formatter #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input logic                  clk,
  input logic                  rst,
  score_bcd_formatter_if.slave bus
);
  localparam int NUM_DIG = 4;
  localparam int CNT_W   = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                      state, state_n;
  logic [BIN_W-1:0]            work;
  logic [NUM_DIG-1:0][3:0]     bcd;
  logic [NUM_DIG-1:0][3:0]     bcd_adj;
  logic [CNT_W-1:0]            cnt;
  logic                        busy_q, done_q;
  logic [15:0]                 hexs_q;
  logic [BIN_W-1:0]            bin_sat;

  assign bin_sat = (bus.bin > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : bus.bin;

  // Every digit is corrected in parallel from its pre-correction value.
  for (genvar d = 0; d < NUM_DIG; d++) begin : g_dig
    score_bcd_add3 u_add3 (.nib(bcd[d]), .adj(bcd_adj[d]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = SHIFT;
      SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work   <= '0;
      bcd    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hexs_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          work   <= bin_sat;
          bcd    <= '0;
          cnt    <= '0;
          busy_q <= 1'b1;
        end
        SHIFT: begin
          {bcd, work} <= {bcd_adj, work} << 1;
          cnt         <= cnt + 1'b1;
        end
        DONE: begin
          hexs_q <= bcd;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  logic [3:0] les_q;
  logic [3:0] mask;

  // Blanking cascades from the thousands digit down; ones is always lit.
  always_comb begin
    mask    = 4'b0000;
    mask[3] = (bcd[3] == 4'd0);
    mask[2] = mask[3] & (bcd[2] == 4'd0);
    mask[1] = mask[2] & (bcd[1] == 4'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               les_q <= 4'b1110;
    else if (state == DONE) les_q <= mask;
  end

  assign bus.LEs = les_q;
`else
  assign bus.LEs = 4'b0000;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hexs = hexs_q;
endmodule
